// File: rtl/mdu_iter_pkg.sv
// mdu_iter_pkg: shared definitions for the iterative multiply/divide unit.
// Holds the operation encodings, the FSM state type, the flag bit positions
// and small helpers used to classify an operation.
package mdu_iter_pkg;

  localparam logic [2:0] OP_MUL   = 3'b000;
  localparam logic [2:0] OP_UMULL = 3'b001;
  localparam logic [2:0] OP_SMULL = 3'b010;
  localparam logic [2:0] OP_UDIV  = 3'b100;
  localparam logic [2:0] OP_SDIV  = 3'b101;

  // Bit positions inside the 2-bit flags output ({N, Z}).
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_RUN  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } mduStateE;

  function automatic logic isDivOp(input logic [2:0] opV);
    return (opV == OP_UDIV) || (opV == OP_SDIV);
  endfunction

  function automatic logic isSignedOp(input logic [2:0] opV);
    return (opV == OP_SMULL) || (opV == OP_SDIV);
  endfunction

endpackage

// File: rtl/mdu_iter_step.sv
// mdu_iter_step: one radix-2 iteration of the multiply/divide engine.
// Purely combinational.
//   isDiv_i   : 1 selects restoring shift-subtract, 0 selects shift-add
//   acc_i     : current {high, low} accumulator
//   operand_i : multiplicand (multiply) or divisor (divide), unsigned magnitude
//   acc_o     : accumulator after this iteration
module mdu_iter_step
  import mdu_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 isDiv_i,
  input  logic [2*WIDTH-1:0]   acc_i,
  input  logic [WIDTH-1:0]     operand_i,
  output logic [2*WIDTH-1:0]   acc_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Multiply: add the multiplicand into the high half when the current
  // multiplier bit (acc bit 0) is set, then shift the whole accumulator right
  // with the carry entering at the top.
  // Divide: shift the partial remainder left by one dividend bit, try the
  // subtraction with one guard bit; a set guard bit means the divisor did not
  // fit, so the shifted remainder is kept and a 0 quotient bit enters.
  always_comb begin
    sum     = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, operand_i} : '0);
    shifted = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
    diff    = shifted - {1'b0, operand_i};
    if (isDiv_i) begin
      if (diff[WIDTH]) begin
        acc_o = {shifted[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
      end else begin
        acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_o = {sum, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mdu_iter.sv
// mdu_iter: iterative radix-2 multiply/divide unit.
// Covers MUL, UMULL, SMULL, UDIV and SDIV with a fixed latency of WIDTH+3
// cycles from the accepting edge to the done pulse.
//   clk, reset : clock and asynchronous active-low reset
//   start      : request, accepted in IDLE or DONE
//   op, a, b   : operation and operands, captured on acceptance
//   busy       : high in PREP, RUN and FIX
//   done       : one-cycle pulse, lo/hi/dbz/flags valid from this cycle
//   lo, hi     : product halves, or quotient/remainder
//   dbz        : divide by zero on the last operation
//   flags      : {N, Z} of the last result
module mdu_iter
  import mdu_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             dbz,
  output logic [1:0]       flags
);

  localparam logic [WIDTH-1:0] CNT_LOAD = WIDTH'(WIDTH - 1);
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);

  mduStateE           state_q, state_d;
  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2:0]         op_q, op_d;
  logic               negRes_q, negRes_d;
  logic               negRem_q, negRem_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic               dbz_q, dbz_d;
  logic [1:0]         flags_q, flags_d;

  logic [2*WIDTH-1:0] stepAcc;
  logic               stepIsDiv;
  logic               signedOp;
  logic [WIDTH-1:0]   absA, absB;
  logic [WIDTH-1:0]   resLo, resHi;
  logic               resDbz;
  logic [1:0]         resFlags;
  logic               isLong;

  assign stepIsDiv = isDivOp(op_q);
  assign signedOp  = isSignedOp(op_q);
  assign absA      = (signedOp && a_q[WIDTH-1]) ? -a_q : a_q;
  assign absB      = (signedOp && b_q[WIDTH-1]) ? -b_q : b_q;

  mdu_iter_step #(.WIDTH(WIDTH)) u_step (
    .isDiv_i   (stepIsDiv),
    .acc_i     (acc_q),
    .operand_i (opnd_q),
    .acc_o     (stepAcc)
  );

  // Final result as it will appear after FIX. The engine works on magnitudes,
  // so signed results are negated here. The most-negative / -1 SDIV case needs
  // no special handling: its magnitude quotient negates back to itself and
  // the remainder is already zero. A zero divisor register means b was zero.
  always_comb begin
    resLo  = '0;
    resHi  = '0;
    resDbz = 1'b0;
    case (op_q)
      OP_MUL, OP_UMULL: begin
        {resHi, resLo} = acc_q;
      end
      OP_SMULL: begin
        {resHi, resLo} = negRes_q ? -acc_q : acc_q;
      end
      OP_UDIV, OP_SDIV: begin
        if (opnd_q == '0) begin
          resDbz = 1'b1;
          resLo  = '1;
          resHi  = a_q;
        end else begin
          resLo = negRes_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
          resHi = negRem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        end
      end
      default: begin
      end
    endcase
    isLong           = (op_q == OP_UMULL) || (op_q == OP_SMULL);
    resFlags         = '0;
    resFlags[FLAG_N] = isLong ? resHi[WIDTH-1] : resLo[WIDTH-1];
    resFlags[FLAG_Z] = isLong ? ({resHi, resLo} == '0) : (resLo == '0);
  end

  // Next-state and next-value logic for the FSM and datapath. Operands are
  // captured on acceptance so later input changes cannot disturb a running
  // operation; outputs only move on the FIX to DONE transition.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    negRes_d = negRes_q;
    negRem_d = negRem_q;
    lo_d     = lo_q;
    hi_d     = hi_q;
    dbz_d    = dbz_q;
    flags_d  = flags_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        negRes_d = signedOp && (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
        negRem_d = (op_q == OP_SDIV) && a_q[WIDTH-1];
        cnt_d    = CNT_LOAD;
        if (stepIsDiv) begin
          acc_d  = {{WIDTH{1'b0}}, absA};
          opnd_d = absB;
        end else begin
          acc_d  = {{WIDTH{1'b0}}, absB};
          opnd_d = absA;
        end
        state_d = ST_RUN;
      end
      ST_RUN: begin
        acc_d = stepAcc;
        if (cnt_q == '0) begin
          state_d = ST_FIX;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_FIX: begin
        lo_d    = resLo;
        hi_d    = resHi;
        dbz_d   = resDbz;
        flags_d = resFlags;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          op_d    = op;
          state_d = ST_PREP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      negRes_q <= 1'b0;
      negRem_q <= 1'b0;
      lo_q     <= '0;
      hi_q     <= '0;
      dbz_q    <= 1'b0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      negRes_q <= negRes_d;
      negRem_q <= negRem_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      dbz_q    <= dbz_d;
      flags_q  <= flags_d;
    end
  end

  assign busy  = (state_q == ST_PREP) || (state_q == ST_RUN) || (state_q == ST_FIX);
  assign done  = (state_q == ST_DONE);
  assign lo    = lo_q;
  assign hi    = hi_q;
  assign dbz   = dbz_q;
  assign flags = flags_q;

endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative multiply/divide unit, parametrised in operand width, for the multi-cycle core. It generalises the single-cycle ALU's low/high result pair to a sequential radix-2 engine that covers 32-bit multiply, unsigned and signed long multiply, and unsigned and signed divide. The main control FSM stalls on `busy` and writes `lo`/`hi` back through the Result path when `done` pulses.

## Interface
- `WIDTH`, 32, operand and result-half width; any even value ≥ 4.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0).
- `start`  in  1  request; sampled only when the unit can accept.
- `op`  in  3  operation:
  - 000 MUL
  - 001 UMULL
  - 010 SMULL
  - 100 UDIV
  - 101 SDIV
  - all others are reserved.
- `a`  in  WIDTH  multiplicand or dividend.
- `b`  in  WIDTH  multiplier or divisor.
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse; `lo`/`hi` are valid from this cycle.
- `lo`  out  WIDTH  product low half, or quotient.
- `hi`  out  WIDTH  product high half, or remainder.
- `dbz`  out  1  divide by zero on the last operation.
- `flags`  out  2  {N, Z} of the last result.

## Operation
- **States:** IDLE, PREP, RUN, FIX, DONE.
- **Acceptance:** `start` is accepted in IDLE or DONE. Acceptance captures `a`, `b` and `op` into internal registers and moves to PREP. Later changes to the inputs have no effect. `start` in PREP, RUN or FIX is ignored.
- **PREP:**
  - For signed ops, take the absolute value of each operand and record the result sign and the remainder sign.
  - Load the WIDTH-bit iteration counter with WIDTH−1.
- **RUN (WIDTH cycles):**
  - Multiply: shift-add into a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract. Quotient bits enter the low half; the partial remainder is kept in the high half.
  - The counter decrements each cycle. Exit to FIX when the counter is 0.
- **FIX:**
  - Two's-complement negate the product or quotient when the result sign is negative.
  - SDIV remainder takes the sign of the dividend; the quotient truncates toward zero.
- **DONE:** `done`=1, then go to IDLE. If `start` is asserted in DONE, go to PREP instead (back-to-back operation).
- **Results:**
  - MUL: `lo` = low WIDTH bits of the product; `hi` = unsigned high half.
  - UDIV/SDIV: `lo` = quotient, `hi` = remainder.
- **Divide by zero (`b`=0, UDIV or SDIV):** `dbz`=1, `lo`=all ones, `hi`=`a`. Latency is unchanged.
- **Signed overflow (SDIV, most-negative ÷ −1):** `lo` = most-negative value, `hi`=0, `dbz`=0.
- **Reserved `op`:** accepted as normal; `lo`=`hi`=0, `dbz`=0, full latency.
- **`flags`:**
  - N = MSB of `hi` for UMULL/SMULL, MSB of `lo` otherwise.
  - Z = (`hi`,`lo`)==0 for long ops, `lo`==0 otherwise.
- **Output hold:** `lo`, `hi`, `dbz` and `flags` update only in the FIX→DONE transition. They hold their value until the next DONE.

## Timing
- **Reset:** while `reset`=0, state is IDLE, counter is 0, and `busy`, `done`, `lo`, `hi`, `dbz` and `flags` are all 0. This is immediate, independent of `clk`.
- **Reset mid-operation:** abandons the operation; no `done` is produced.
- **Latency:** `start` sampled at edge 0 → PREP in cycle 1 → RUN in cycles 2..WIDTH+1 → FIX in cycle WIDTH+2 → DONE (`done`=1) in cycle WIDTH+3.
- **`busy`:** 1 exactly in cycles 1..WIDTH+2, so `busy`=1 whenever the state is PREP, RUN or FIX.
- **`busy`/`done` overlap:** never both high.
- **Throughput:** one operation per WIDTH+3 cycles when `start` is held high.

## Structure
- Shared include `mdu_defs.vh`:
  - op encodings (MUL, UMULL, SMULL, UDIV, SDIV)
  - FSM state encodings (3-bit)
  - flag bit positions
- Single module. The datapath (accumulator, divisor register, sign bits, counter) and the FSM live in one `always` block with a combinational next-state and next-value section.
- One natural sub-module: `mdu_step`, the combinational single-iteration add/subtract-and-shift cell. It is instantiated once.

## Test plan
1. **UMULL, WIDTH=32:** `a`=0xFFFFFFFF, `b`=0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001. `done` at cycle 35; `busy` high in cycles 1–34.
2. **SMULL:** `a`=−3, `b`=7 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB, N=1, Z=0. **MUL:** 0x10000×0x10000 → `lo`=0, Z=1.
3. **UDIV:** 100/7 → `lo`=14, `hi`=2. **SDIV:** −7/2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
4. **Divide edge cases:**
   - UDIV 5/0 → `dbz`=1, `lo`=0xFFFFFFFF, `hi`=5.
   - SDIV 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0, `dbz`=0.
5. **Handshake:**
   - Assert `start` with new operands at cycle 10 of a busy operation → ignored; the first result is unaffected.
   - Hold `start` high in the DONE cycle → `busy` rises on the next cycle and the second `done` arrives 35 cycles after the first.
6. **Reset and width:**
   - Drive `reset`=0 during RUN → all outputs 0 immediately and no `done` pulse.
   - WIDTH=8, UMULL 0xFF×0xFF → `hi`=0xFE, `lo`=0x01, `done` at cycle 11.
